// File: rtl/mux_8to1_u_4to1_2to1.sv
// mux_8to1_u_4to1_2to1: registered 8:1 selector built from two 4:1 muxes and a final 2:1 mux
module mux_2to1 #(
  parameter int WIDTH = 1
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] l01, l23;
  mux_2to1 #(.WIDTH(WIDTH)) u_l01 (.s(s0), .a(a0),  .b(a1),  .y(l01));
  mux_2to1 #(.WIDTH(WIDTH)) u_l23 (.s(s0), .a(a2),  .b(a3),  .y(l23));
  mux_2to1 #(.WIDTH(WIDTH)) u_top (.s(s1), .a(l01), .b(l23), .y(y));
endmodule

module mux_8to1_u_4to1_2to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] mux_lo, mux_hi, out_d, out_q;
  mux_4to1 #(.WIDTH(WIDTH)) u_lo (
    .s0(s0), .s1(s1), .a0(in0), .a1(in1), .a2(in2), .a3(in3), .y(mux_lo)
  );
  mux_4to1 #(.WIDTH(WIDTH)) u_hi (
    .s0(s0), .s1(s1), .a0(in4), .a1(in5), .a2(in6), .a3(in7), .y(mux_hi)
  );
  mux_2to1 #(.WIDTH(WIDTH)) u_fin (.s(s2), .a(mux_lo), .b(mux_hi), .y(out_d));
  // capture the selection each edge; reset overrides any select activity
  always_ff @(posedge clk)
    out_q <= rst ? '0 : out_d;
  assign out = out_q;
endmodule

// File: tb/tb_mux_8to1_u_4to1_2to1.sv
// tb_mux_8to1_u_4to1_2to1: directed checks of the registered 8:1 selector at WIDTH 1 and 8
module tb_mux_8to1_u_4to1_2to1;
  logic clk = 1'b0;
  logic rst;
  logic s0, s1, s2;
  logic [7:0] d1;
  logic [7:0] d8 [8];
  logic       o1;
  logic [7:0] o8;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_8to1_u_4to1_2to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .in0(d1[0]), .in1(d1[1]), .in2(d1[2]), .in3(d1[3]),
    .in4(d1[4]), .in5(d1[5]), .in6(d1[6]), .in7(d1[7]),
    .s0(s0), .s1(s1), .s2(s2), .out(o1)
  );

  mux_8to1_u_4to1_2to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in0(d8[0]), .in1(d8[1]), .in2(d8[2]), .in3(d8[3]),
    .in4(d8[4]), .in5(d8[5]), .in6(d8[6]), .in7(d8[7]),
    .s0(s0), .s1(s1), .s2(s2), .out(o8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_sel(input logic [2:0] c);
    {s2, s1, s0} = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_sel(3'b000);
    d1 = 8'h01;
    for (int i = 0; i < 8; i++) d8[i] = 8'h00;
    step();
    step();
    check("reset_w1", {7'd0, o1}, 8'h00);
    check("reset_w8", o8, 8'h00);
    rst = 1'b0;
    step();
    check("release_w1", {7'd0, o1}, 8'h01);
    d1 = 8'b0101_0101;
    for (int i = 0; i < 8; i++) d8[i] = 8'(i * 8'h11);
    for (int c = 0; c < 8; c++) begin
      set_sel(3'(c));
      step();
      check("sweep_w1", {7'd0, o1}, (c % 2 == 0) ? 8'h01 : 8'h00);
      check("sweep_w8", o8, 8'(c * 8'h11));
    end
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 8; c++) begin
        d1 = 8'h01 << p;
        set_sel(3'(c));
        step();
        check("onehot", {7'd0, o1}, (c == p) ? 8'h01 : 8'h00);
      end
    end
    d1 = 8'h00;
    set_sel(3'b101);
    step();
    check("lat_pre", {7'd0, o1}, 8'h00);
    #2 d1[5] = 1'b1;
    #2 check("lat_hold", {7'd0, o1}, 8'h00);
    step();
    check("lat_edge", {7'd0, o1}, 8'h01);
    d1 = 8'h40;
    d8[6] = 8'hA5;
    set_sel(3'b110);
    step();
    check("mid_pre", {7'd0, o1}, 8'h01);
    check("mid_pre_w8", o8, 8'hA5);
    rst = 1'b1;
    step();
    check("mid_rst", {7'd0, o1}, 8'h00);
    check("mid_rst_w8", o8, 8'h00);
    rst = 1'b0;
    step();
    check("mid_rel", {7'd0, o1}, 8'h01);
    check("mid_rel_w8", o8, 8'hA5);
    d8[3] = 8'h3C;
    set_sel(3'b011);
    rst = 1'b1;
    step();
    check("rst_wins", o8, 8'h00);
    rst = 1'b0;
    step();
    check("rst_nobubble", o8, 8'h3C);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
